// File: rtl/reg_alu_ctrl_pkg.sv
// Shared definitions for the reg_alu controller: instruction classes, FSM states
// and instruction field positions.
package reg_alu_ctrl_pkg;

    localparam int unsigned InstrW = 16;

    // Instruction class lives in [15:14].
    localparam int unsigned ClsLo = 14;
    localparam int unsigned OpLo  = 12;
    localparam int unsigned RdLo  = 9;
    localparam int unsigned RaLo  = 6;
    localparam int unsigned RbLo  = 3;

    typedef enum logic [1:0] {
        ClsLoad = 2'b00,
        ClsAlu  = 2'b01,
        ClsRead = 2'b10,
        ClsRsvd = 2'b11
    } instr_cls_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic instr_cls_e instr_cls(input logic [InstrW-1:0] instr);
        return instr_cls_e'(instr[ClsLo +: 2]);
    endfunction

endpackage

// File: rtl/reg_alu_ctrl_decode.sv
// Combinational decode of the latched instruction into reg_alu control fields.
// Every output is zero unless the controller is in its execute cycle.
module reg_alu_ctrl_decode
    import reg_alu_ctrl_pkg::*;
#(
    parameter int unsigned DataW = 16,
    parameter int unsigned AddrW = 3
) (
    input  logic [InstrW-1:0] instr_i,
    input  logic [DataW-1:0]  imm_i,
    input  logic              exec_i,
    output logic              wr_o,
    output logic              sel_o,
    output logic [1:0]        op_o,
    output logic [AddrW-1:0]  rd_a_o,
    output logic [AddrW-1:0]  rd_b_o,
    output logic [AddrW-1:0]  wr_addr_o,
    output logic [DataW-1:0]  d_in_o,
    output logic              is_alu_o,
    output logic              is_read_o,
    output logic              retire_o,
    output logic              illegal_o
);

    // Low bits carry no field in any class.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[RbLo-1:0];

    // Decode class and fields while executing.
    always_comb begin
        wr_o      = 1'b0;
        sel_o     = 1'b0;
        op_o      = '0;
        rd_a_o    = '0;
        rd_b_o    = '0;
        wr_addr_o = '0;
        d_in_o    = '0;
        is_alu_o  = 1'b0;
        is_read_o = 1'b0;
        retire_o  = 1'b0;
        illegal_o = 1'b0;
        if (exec_i) begin
            unique case (instr_cls(instr_i))
                ClsLoad: begin
                    wr_o      = 1'b1;
                    wr_addr_o = instr_i[RdLo +: AddrW];
                    d_in_o    = imm_i;
                    retire_o  = 1'b1;
                end
                ClsAlu: begin
                    wr_o      = 1'b1;
                    sel_o     = 1'b1;
                    op_o      = instr_i[OpLo +: 2];
                    rd_a_o    = instr_i[RaLo +: AddrW];
                    rd_b_o    = instr_i[RbLo +: AddrW];
                    wr_addr_o = instr_i[RdLo +: AddrW];
                    is_alu_o  = 1'b1;
                    retire_o  = 1'b1;
                end
                ClsRead: begin
                    rd_a_o    = instr_i[RaLo +: AddrW];
                    is_read_o = 1'b1;
                end
                ClsRsvd: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Instruction sequencer for reg_alu: valid/ready instruction intake, one execute
// cycle per instruction, a response handshake for reads, sticky carry and a
// retired-instruction counter.
module reg_alu_ctrl
    import reg_alu_ctrl_pkg::*;
#(
    parameter int unsigned DataW = 16,
    parameter int unsigned AddrW = 3,
    parameter int unsigned CntW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [InstrW-1:0] instr_i,
    input  logic [DataW-1:0]  imm_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DataW-1:0]  rsp_data_o,
    output logic              ra_sel_o,
    output logic              ra_wr_o,
    output logic [1:0]        ra_op_o,
    output logic [AddrW-1:0]  ra_rd_a_o,
    output logic [AddrW-1:0]  ra_rd_b_o,
    output logic [AddrW-1:0]  ra_wr_addr_o,
    output logic [DataW-1:0]  ra_d_in_o,
    input  logic [DataW-1:0]  ra_dout_a_i,
    input  logic              ra_cout_i,
    output logic              carry_o,
    output logic              illegal_o,
    output logic [CntW-1:0]   retired_o
);

    state_e            state_q, state_d;
    logic [InstrW-1:0] instr_q, instr_d;
    logic [DataW-1:0]  imm_q, imm_d;
    logic [DataW-1:0]  rsp_data_q, rsp_data_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   retired_q, retired_d;

    logic dec_alu, dec_read, dec_retire;

    reg_alu_ctrl_decode #(
        .DataW (DataW),
        .AddrW (AddrW)
    ) u_decode (
        .instr_i   (instr_q),
        .imm_i     (imm_q),
        .exec_i    (state_q == StExec),
        .wr_o      (ra_wr_o),
        .sel_o     (ra_sel_o),
        .op_o      (ra_op_o),
        .rd_a_o    (ra_rd_a_o),
        .rd_b_o    (ra_rd_b_o),
        .wr_addr_o (ra_wr_addr_o),
        .d_in_o    (ra_d_in_o),
        .is_alu_o  (dec_alu),
        .is_read_o (dec_read),
        .retire_o  (dec_retire),
        .illegal_o (illegal_o)
    );

    // Ready is held low while reset is asserted, even though state is already idle.
    assign instr_ready_o = rst_ni && (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_data_o    = rsp_data_q;
    assign carry_o       = carry_q;
    assign retired_o     = retired_q;

    // Next-state: intake in idle, side effects on execute exit, retire reads on handshake.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        rsp_data_d = rsp_data_q;
        carry_d    = carry_q;
        retired_d  = retired_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    imm_d   = imm_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = dec_read ? StResp : StIdle;
                if (dec_read) begin
                    rsp_data_d = ra_dout_a_i;
                end
                if (dec_alu) begin
                    carry_d = ra_cout_i;
                end
                if (dec_retire) begin
                    retired_d = retired_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d   = StIdle;
                    retired_d = retired_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state; async reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            imm_q      <= '0;
            rsp_data_q <= '0;
            carry_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            imm_q      <= imm_d;
            rsp_data_q <= rsp_data_d;
            carry_q    <= carry_d;
            retired_q  <= retired_d;
        end
    end

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Bench for reg_alu_ctrl with a behavioural reg_alu beside it. Expected results
// come from a register-array model updated per instruction; a negedge process
// compares the DUT outputs against the model every cycle.
module tb_reg_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] imm = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        ra_sel, ra_wr, ra_cout, carry, illegal;
    logic [1:0]  ra_op;
    logic [2:0]  ra_rd_a, ra_rd_b, ra_wr_addr;
    logic [15:0] ra_d_in, ra_dout_a, ra_dout_b, retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_alu_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .imm_i         (imm),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .ra_sel_o      (ra_sel),
        .ra_wr_o       (ra_wr),
        .ra_op_o       (ra_op),
        .ra_rd_a_o     (ra_rd_a),
        .ra_rd_b_o     (ra_rd_b),
        .ra_wr_addr_o  (ra_wr_addr),
        .ra_d_in_o     (ra_d_in),
        .ra_dout_a_i   (ra_dout_a),
        .ra_cout_i     (ra_cout),
        .carry_o       (carry),
        .illegal_o     (illegal),
        .retired_o     (retired)
    );

    // Behavioural reg_alu: 8x16 registers, combinational reads, write on clock.
    logic [15:0] ra_regs [8];
    logic [16:0] ra_res;
    assign ra_dout_a = ra_regs[ra_rd_a];
    assign ra_dout_b = ra_regs[ra_rd_b];
    always_comb begin
        ra_res = '0;
        case (ra_op)
            2'b00: ra_res = {1'b0, ra_dout_a} + {1'b0, ra_dout_b};
            2'b01: ra_res = {1'b0, ra_dout_a - ra_dout_b};
            2'b10: ra_res = {1'b0, ra_dout_a & ra_dout_b};
            default: ra_res = {1'b0, ra_dout_a | ra_dout_b};
        endcase
    end
    assign ra_cout = ra_res[16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) ra_regs[i] <= '0;
        end else if (ra_wr) begin
            ra_regs[ra_wr_addr] <= ra_sel ? ra_res[15:0] : ra_d_in;
        end
    end

    // Model state and expected outputs.
    logic [15:0] exp_regs [8];
    logic        exp_ready = 1'b0, exp_rsp_valid = 1'b0, exp_wr = 1'b0, exp_sel = 1'b0;
    logic        exp_illegal = 1'b0, exp_carry = 1'b0;
    logic [2:0]  exp_wr_addr = '0;
    logic [15:0] exp_d_in = '0, exp_rsp = '0, exp_retired = '0;
    logic [15:0] last_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_valid});
        if (exp_rsp_valid) check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rsp});
        check("ra_wr", {31'd0, ra_wr}, {31'd0, exp_wr});
        check("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
        if (exp_wr) begin
            check("ra_sel", {31'd0, ra_sel}, {31'd0, exp_sel});
            check("ra_wr_addr", {29'd0, ra_wr_addr}, {29'd0, exp_wr_addr});
            if (!exp_sel) check("ra_d_in", {16'd0, ra_d_in}, {16'd0, exp_d_in});
        end
        check("carry", {31'd0, carry}, {31'd0, exp_carry});
        check("retired", {16'd0, retired}, {16'd0, exp_retired});
    end

    function automatic logic [15:0] mk_load(input logic [2:0] rd);
        return {2'b00, 2'b00, rd, 9'd0};
    endfunction
    function automatic logic [15:0] mk_add(input logic [2:0] rd, input logic [2:0] ra,
                                           input logic [2:0] rb);
        return {2'b01, 2'b00, rd, ra, rb, 3'd0};
    endfunction
    function automatic logic [15:0] mk_read(input logic [2:0] ra);
        return {2'b10, 5'd0, ra, 6'd0};
    endfunction

    // Issue one instruction and follow it to completion, updating the model.
    // For reads, rsp_ready is held low for 'hold' cycles; 'offer' presents the
    // next instruction while the response is pending.
    task automatic run(input logic [15:0] ins, input logic [15:0] im, input int hold,
                       input logic offer, input logic [15:0] nins, input logic [15:0] nim);
        int          waited;
        logic [1:0]  cls;
        logic [16:0] sum;
        waited      = 0;
        instr_valid = 1'b1;
        instr       = ins;
        imm         = im;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                instr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        cls         = ins[15:14];
        exp_ready   = 1'b0;
        exp_wr      = (cls == 2'b00) || (cls == 2'b01);
        exp_sel     = (cls == 2'b01);
        exp_wr_addr = ins[11:9];
        exp_d_in    = im;
        exp_illegal = (cls == 2'b11);
        @(posedge clk);
        #1;
        exp_wr      = 1'b0;
        exp_illegal = 1'b0;
        case (cls)
            2'b00: begin
                exp_regs[ins[11:9]] = im;
                exp_retired++;
                exp_ready = 1'b1;
            end
            2'b01: begin
                sum = {1'b0, exp_regs[ins[8:6]]} + {1'b0, exp_regs[ins[5:3]]};
                exp_regs[ins[11:9]] = sum[15:0];
                exp_carry = sum[16];
                exp_retired++;
                exp_ready = 1'b1;
            end
            2'b10: begin
                exp_rsp       = exp_regs[ins[8:6]];
                exp_rsp_valid = 1'b1;
                last_rsp      = rsp_data;
                if (offer) begin
                    instr_valid = 1'b1;
                    instr       = nins;
                    imm         = nim;
                end
                repeat (hold) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready     = 1'b0;
                exp_rsp_valid = 1'b0;
                exp_retired++;
                exp_ready = 1'b1;
            end
            default: exp_ready = 1'b1;
        endcase
    endtask

    task automatic run1(input logic [15:0] ins, input logic [15:0] im);
        run(ins, im, 0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        exp_ready     = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_wr        = 1'b0;
        exp_illegal   = 1'b0;
        exp_carry     = 1'b0;
        exp_retired   = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_wr_addr", {29'd0, ra_wr_addr}, 32'd0);
        check("rst_d_in", {16'd0, ra_d_in}, 32'd0);
        check("rst_op_rd", {26'd0, ra_op, ra_rd_a, ra_rd_b}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_ready = 1'b1;

        // 1: loads and reads
        run1(mk_load(3'd1), 16'h0005);
        run1(mk_load(3'd2), 16'h0003);
        run1(mk_read(3'd1), 16'h0);
        check("t1_read_r1", {16'd0, last_rsp}, 32'h0005);
        run1(mk_read(3'd2), 16'h0);
        check("t1_read_r2", {16'd0, last_rsp}, 32'h0003);
        check("t1_retired", {16'd0, retired}, 32'd4);

        // 2: add without carry
        run1(mk_add(3'd3, 3'd1, 3'd2), 16'h0);
        run1(mk_read(3'd3), 16'h0);
        check("t2_read_r3", {16'd0, last_rsp}, 32'h0008);
        check("t2_carry", {31'd0, carry}, 32'd0);

        // 3: add with carry out, then rd == ra == rb
        run1(mk_load(3'd4), 16'hFFFF);
        run1(mk_load(3'd5), 16'h0001);
        run1(mk_add(3'd6, 3'd4, 3'd5), 16'h0);
        run1(mk_read(3'd6), 16'h0);
        check("t3_read_r6", {16'd0, last_rsp}, 32'h0000);
        check("t3_carry_set", {31'd0, carry}, 32'd1);
        run1(mk_add(3'd1, 3'd1, 3'd1), 16'h0);
        check("t3_carry_clr", {31'd0, carry}, 32'd0);
        run1(mk_read(3'd1), 16'h0);
        check("t3_read_r1", {16'd0, last_rsp}, 32'h000A);
        check("t3_retired", {16'd0, retired}, 32'd12);

        // 4: response back-pressure with a competing instruction offered
        run(mk_read(3'd3), 16'h0, 10, 1'b1, mk_load(3'd7), 16'h00AA);
        check("t4_ready_after_hs", {31'd0, instr_ready}, 32'd1);
        run1(mk_load(3'd7), 16'h00AA);
        run1(mk_read(3'd7), 16'h0);
        check("t4_read_r7", {16'd0, last_rsp}, 32'h00AA);

        // 5: reserved opcode, then async reset during a load's execute cycle
        run1(16'hC000, 16'h0);
        check("t5_rsvd_retired", {16'd0, retired}, 32'd15);
        instr_valid = 1'b1;
        instr       = mk_load(3'd7);
        imm         = 16'h1234;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("t5_exec_wr", {31'd0, ra_wr}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_wr", {31'd0, ra_wr}, 32'd0);
        check("t5_async_ready", {31'd0, instr_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_ready = 1'b1;
        run1(mk_read(3'd7), 16'h0);
        check("t5_read_after_rst", {16'd0, last_rsp}, 32'h0000);

        // 6: counter wrap
        @(posedge clk);
        #1;
        force dut.retired_q = 16'hFFFC;
        exp_retired = 16'hFFFC;
        @(posedge clk);
        #1;
        release dut.retired_q;
        run1(mk_load(3'd1), 16'h0011);
        run1(mk_load(3'd2), 16'h0022);
        check("t6_retired_fffe", {16'd0, retired}, 32'hFFFE);
        run1(mk_load(3'd3), 16'h0033);
        run1(mk_load(3'd4), 16'h0044);
        run1(mk_load(3'd5), 16'h0055);
        check("t6_retired_wrap", {16'd0, retired}, 32'h0001);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
